wb_sequencer: RTL
=================

WB_SEQUENCER -- requirements
Module: wb_sequencer

Interface
REQ-001 Parameter DATA_W, default 16, width of one register-file word; the packed result is 2*DATA_W.
REQ-002 Parameter REG_AW, default 4, register-file address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  ALU result presented.
REQ-006 in_ready  output  1  block accepts a result this cycle; transfer occurs when in_valid and in_ready are both 1 at a rising edge.
REQ-007 in_result  input  2*DATA_W  packed ALU result {hi, lo}; hi meaningful only for SWAP.
REQ-008 in_op  input  3  ALU control code: 000 ADD, 001 SUB, 010 MOVE, 011 SWAP, 100 AND, 101-111 OR.
REQ-009 in_ovf  input  1  ALU overflow flag.
REQ-010 in_rd  input  REG_AW  destination for lo.
REQ-011 in_rs  input  REG_AW  destination for hi (SWAP only).
REQ-012 in_pc  input  16  PC of the instruction.
REQ-013 rf_we  output  1  register-file write enable.
REQ-014 rf_waddr  output  REG_AW  write address.
REQ-015 rf_wdata  output  DATA_W  write data.
REQ-016 exc  output  1  one-cycle overflow trap pulse.
REQ-017 epc  output  16  PC of the last trapped instruction.

Function
REQ-018 The FSM SHALL have states IDLE, WR1, WR2 and TRAP; all outputs except in_ready SHALL be registered.
REQ-019 Accept in IDLE SHALL capture in_result, in_op, in_rd, in_rs, in_pc and move to WR1, or to TRAP per REQ-030.
REQ-020 In WR1, rf_we SHALL be 1, rf_waddr = captured rd and rf_wdata = captured lo, one cycle after accept.
REQ-021 From WR1, a captured SWAP SHALL go to WR2; any other op SHALL go to IDLE, or to WR1/TRAP if a new transfer occurs in the same cycle.
REQ-022 In WR2, rf_we SHALL be 1, rf_waddr = captured rs and rf_wdata = captured hi; WR2 SHALL then go to IDLE, or to WR1/TRAP on a same-cycle accept.
REQ-023 in_ready SHALL be 1 in IDLE, in WR2, and in WR1 when the captured op is not SWAP; it SHALL be 0 in TRAP and in WR1 holding a SWAP.
REQ-024 Throughput SHALL be one non-SWAP result per cycle back-to-back; a SWAP SHALL occupy two write cycles.
REQ-025 In IDLE and TRAP, rf_we SHALL be 0; rf_waddr and rf_wdata hold their last values.
REQ-026 A SWAP with in_rd == in_rs SHALL perform both writes in order; the hi value remains in the register.
REQ-027 in_valid with in_ready low SHALL be ignored, with no capture or state change.

Reset
REQ-028 Asserting rst at any time, including mid-SWAP, SHALL force state IDLE and set rf_we, rf_waddr, rf_wdata, exc and epc to 0; any pending WR2 write is discarded.
REQ-029 in_ready SHALL be 1 while rst is asserted and on the first cycle after release.

Configuration
REQ-030 With OVF_TRAP_EN defined, accepting ADD or SUB with in_ovf=1 SHALL suppress all writes for that instruction, enter TRAP for one cycle with exc=1, latch epc = in_pc, then return to IDLE.
REQ-031 With OVF_TRAP_EN defined, in_ovf SHALL be ignored for opcodes 010-111.
REQ-032 Without OVF_TRAP_EN, the TRAP state SHALL be absent, in_ovf SHALL be ignored (overflowed results are written normally), and exc and epc SHALL be constant 0.

Verification
REQ-033 ADD result 0x0000_1234, rd=3, valid one cycle -> next cycle rf_we=1, waddr=3, wdata=0x1234; then rf_we=0.
REQ-034 SWAP result 0xBEEF_CAFE, rd=2, rs=5 -> cycle+1: write 2<-0xCAFE with in_ready=0; cycle+2: write 5<-0xBEEF with in_ready=1.
REQ-035 Four back-to-back OR results to rd=1..4 with in_valid held -> four consecutive write cycles, in_ready constantly 1.
REQ-036 With OVF_TRAP_EN: SUB, ovf=1, pc=0x0040 -> no write, exc=1 for one cycle, epc=0x0040, in_ready=0 that cycle; without the macro -> normal write, exc=0.
REQ-037 Assert rst during the WR1 cycle of a SWAP -> no WR2 write occurs; all outputs 0; in_ready=1 after release.

Source files
------------

// File: rtl/wb_sequencer.sv
// Register-file write sequencer for ALU results; SWAP results are written as two words.
// Optional overflow trap on ADD/SUB is enabled by defining OVF_TRAP_EN.
module wb_sequencer #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2*DATA_W-1:0]   in_result,
   input  logic [2:0]            in_op,
   input  logic                  in_ovf,
   input  logic [REG_AW-1:0]     in_rd,
   input  logic [REG_AW-1:0]     in_rs,
   input  logic [15:0]           in_pc,
   output logic                  rf_we,
   output logic [REG_AW-1:0]     rf_waddr,
   output logic [DATA_W-1:0]     rf_wdata,
   output logic                  exc,
   output logic [15:0]           epc
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WR1  = 2'd1;
   localparam logic [1:0] WR2  = 2'd2;
`ifdef OVF_TRAP_EN
   localparam logic [1:0] TRAP = 2'd3;
`endif

   logic [1:0]        state;
   logic              cap_swap;
   logic [REG_AW-1:0] cap_rs;
   logic [DATA_W-1:0] cap_hi;
   logic              accept;
   logic              in_swap;
   logic              trap_hit;

   // Ready is combinational so a non-SWAP result can be accepted every cycle.
   assign in_ready = (state == IDLE) || (state == WR2) || ((state == WR1) && !cap_swap);
   assign accept   = in_valid && in_ready;
   assign in_swap  = (in_op == 3'b011);

`ifdef OVF_TRAP_EN
   assign trap_hit = (in_op[2:1] == 2'b00) && in_ovf;
`else
   logic unused_trap_inputs;
   assign trap_hit = 1'b0;
   assign unused_trap_inputs = ^{in_ovf, in_pc};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cap_swap <= 1'b0;
         cap_rs   <= '0;
         cap_hi   <= '0;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else if (accept) begin
         cap_swap <= in_swap;
         cap_rs   <= in_rs;
         cap_hi   <= in_result[2*DATA_W-1:DATA_W];
`ifdef OVF_TRAP_EN
         if (trap_hit) begin
            state <= TRAP;
            rf_we <= 1'b0;
         end else begin
            state    <= WR1;
            rf_we    <= 1'b1;
            rf_waddr <= in_rd;
            rf_wdata <= in_result[DATA_W-1:0];
         end
`else
         state    <= WR1;
         rf_we    <= 1'b1;
         rf_waddr <= in_rd;
         rf_wdata <= in_result[DATA_W-1:0];
`endif
      end else if ((state == WR1) && cap_swap) begin
         state    <= WR2;
         rf_we    <= 1'b1;
         rf_waddr <= cap_rs;
         rf_wdata <= cap_hi;
      end else begin
         state <= IDLE;
         rf_we <= 1'b0;
      end
   end

`ifdef OVF_TRAP_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exc <= 1'b0;
         epc <= '0;
      end else begin
         exc <= accept && trap_hit;
         if (accept && trap_hit)
            epc <= in_pc;
      end
   end
`else
   assign exc = 1'b0;
   assign epc = '0;
`endif

endmodule
